// File: rtl/light_sched.sv
// Ambient-light conversion scheduler: periodic ADC requests, windowed
// averaging, hysteresis and PWM duty publication.
module light_sched #(
  parameter int PERIOD   = 24000,
  parameter int AVG_LOG2 = 3,
  parameter int HYST     = 4,
  parameter int TIMEOUT  = 1023,
  parameter bit INVERT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       conv_start,
  input  logic       conv_done,
  input  logic [7:0] conv_data,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int NS = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE, WAIT, START, CONV, UPD
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [TW-1:0]   tcnt_q, tnext;
  logic [AW-1:0]   acc_q, sum;
  logic [CW-1:0]   cnt_q;
  logic            first_q;
  logic            start_q;
  logic            dv_q;
  logic            err_q;
  logic [7:0]      duty_q;
  logic [7:0]      avg, cand, diff;
  logic            tick, last, wr, to;

  always_comb begin
    pcnt_d = '0;
    if (en && pcnt_q != PW'(PERIOD - 1))
      pcnt_d = pcnt_q + 1'b1;
  end

  assign tick  = en && (pcnt_q == PW'(PERIOD - 1));
  assign tnext = tcnt_q + 1'b1;
  assign to    = (tnext == TW'(TIMEOUT));
  assign last  = (cnt_q == CW'(NS - 1));

  // Window decision is taken on the completing sample so duty lands next cycle
  assign sum  = acc_q + AW'(conv_data);
  assign avg  = 8'(sum >> AVG_LOG2);
  assign cand = INVERT ? (8'd255 - avg) : avg;
  assign diff = (cand >= duty_q) ? (cand - duty_q)
                                 : (duty_q - cand);
  assign wr   = first_q || ({1'b0, diff} >= 9'(HYST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      duty_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      start_q <= 1'b0;
      dv_q    <= 1'b0;
      if (err_clr) err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          acc_q   <= '0;
          cnt_q   <= '0;
          first_q <= 1'b1;
          if (en) state_q <= WAIT;
        end
        WAIT: begin
          tcnt_q <= '0;
          if (!en) begin
            state_q <= IDLE;
          end else if (tick) begin
            state_q <= START;
            start_q <= 1'b1;
          end
        end
        START: begin
          tcnt_q  <= TW'(1);
          state_q <= CONV;
        end
        CONV: begin
          tcnt_q <= tnext;
          if (conv_done) begin
            if (!en) begin
              state_q <= IDLE;
            end else if (last) begin
              state_q <= UPD;
              acc_q   <= '0;
              cnt_q   <= '0;
              if (wr) begin
                duty_q  <= cand;
                dv_q    <= 1'b1;
                first_q <= 1'b0;
              end
            end else begin
              state_q <= WAIT;
              acc_q   <= sum;
              cnt_q   <= cnt_q + 1'b1;
            end
          end else if (to) begin
            err_q   <= 1'b1;
            state_q <= en ? WAIT : IDLE;
          end
        end
        UPD:     state_q <= WAIT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conv_start  = start_q;
  assign duty        = duty_q;
  assign duty_valid  = dv_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_light_sched.sv
// Bench for light_sched: acts as capture engine, compares both polarities
// against a window/hysteresis reference model.
module tb_light_sched;

  localparam int PERIOD   = 16;
  localparam int AVG_LOG2 = 2;
  localparam int HYST     = 4;
  localparam int TIMEOUT  = 8;
  localparam int NS       = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       rst, en, conv_done, err_clr;
  logic [7:0] conv_data;
  logic       start_a, dv_a, err_a;
  logic [7:0] duty_a;
  logic       start_b, dv_b, err_b;
  logic [7:0] duty_b;

  always #5 clk = ~clk;

  light_sched #(.PERIOD(PERIOD), .AVG_LOG2(AVG_LOG2), .HYST(HYST),
    .TIMEOUT(TIMEOUT), .INVERT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .conv_start(start_a),
    .conv_done(conv_done), .conv_data(conv_data), .duty(duty_a),
    .duty_valid(dv_a), .timeout_err(err_a), .err_clr(err_clr));

  light_sched #(.PERIOD(PERIOD), .AVG_LOG2(AVG_LOG2), .HYST(HYST),
    .TIMEOUT(TIMEOUT), .INVERT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .conv_start(start_b),
    .conv_done(conv_done), .conv_data(conv_data), .duty(duty_b),
    .duty_valid(dv_b), .timeout_err(err_b), .err_clr(err_clr));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev_start;

  int m_sum, m_n, m_duty_a, m_duty_b;
  bit m_first, m_err;

  task automatic model_reset();
    m_sum = 0; m_n = 0; m_first = 1;
    m_duty_a = 0; m_duty_b = 0; m_err = 0;
    prev_start = -1;
  endtask

  task automatic model_disable();
    m_sum = 0; m_n = 0; m_first = 1;
    prev_start = -1;
  endtask

  task automatic model_sample(input int data, output bit wr);
    int avg, dlt;
    wr = 0;
    m_sum += data;
    m_n++;
    if (m_n == NS) begin
      avg = m_sum / NS;
      dlt = avg - m_duty_a;
      if (dlt < 0) dlt = -dlt;
      if (m_first || dlt >= HYST) begin
        wr = 1;
        m_duty_a = avg;
        m_duty_b = 255 - avg;
        m_first = 0;
      end
      m_sum = 0;
      m_n = 0;
    end
  endtask

  task automatic tick_c();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      tick_c();
      if (start_a) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL start_seen: no conv_start in 64 cycles, required one");
    end else begin
      if (prev_start >= 0) begin
        n_checks++;
        if (cyc - prev_start != PERIOD) begin
          n_fail++;
          $display("FAIL start_period: interval %0d, required %0d",
                   cyc - prev_start, PERIOD);
        end
      end
      prev_start = cyc;
    end
  endtask

  // d>0: conv_done d cycles after conv_start; d==0: withhold it
  task automatic do_conv(input int d, input int data, input bit clr_hit);
    bit ok, wr;
    wait_start(ok);
    if (!ok) return;
    if (d > 0) begin
      repeat (d) tick_c();
      conv_done = 1'b1;
      conv_data = 8'(data);
      tick_c();
      conv_done = 1'b0;
      model_sample(data, wr);
      n_checks++;
      if (dv_a !== wr || dv_b !== wr || duty_a !== 8'(m_duty_a) ||
          duty_b !== 8'(m_duty_b) || err_a !== m_err) begin
        n_fail++;
        $display("FAIL conv_update: dv %b/%b duty %0d/%0d err %b, required dv %b duty %0d/%0d err %b",
                 dv_a, dv_b, duty_a, duty_b, err_a, wr, m_duty_a,
                 m_duty_b, m_err);
      end
    end else begin
      repeat (TIMEOUT - 1) tick_c();
      n_checks++;
      if (err_a !== m_err) begin
        n_fail++;
        $display("FAIL timeout_early: err %b, required %b", err_a, m_err);
      end
      if (clr_hit) err_clr = 1'b1;
      tick_c();
      err_clr = 1'b0;
      m_err = 1;
      n_checks++;
      if (err_a !== 1'b1 || err_b !== 1'b1 || dv_a !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_set: err %b/%b dv %b, required err 1 dv 0",
                 err_a, err_b, dv_a);
      end
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick_c();
    err_clr = 1'b0;
    m_err = 0;
    n_checks++;
    if (err_a !== 1'b0 || duty_a !== 8'(m_duty_a)) begin
      n_fail++;
      $display("FAIL err_clear: err %b duty %0d, required err 0 duty %0d",
               err_a, duty_a, m_duty_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; conv_done = 1'b0;
    conv_data = '0; err_clr = 1'b0;
    model_reset();
    repeat (3) tick_c();
    rst = 1'b0;
    tick_c();
    n_checks++;
    if (start_a !== 0 || dv_a !== 0 || duty_a !== 0 || err_a !== 0 ||
        start_b !== 0 || dv_b !== 0 || duty_b !== 0 || err_b !== 0) begin
      n_fail++;
      $display("FAIL reset_state: start %b dv %b duty %0d err %b, required all 0",
               start_a, dv_a, duty_a, err_a);
    end
  endtask

  task automatic test_basic();
    int vals [4] = '{10, 20, 30, 40};
    en = 1'b1;
    foreach (vals[i]) do_conv(5, vals[i], 1'b0);
    n_checks++;
    if (duty_a !== 8'd25 || duty_b !== 8'd230) begin
      n_fail++;
      $display("FAIL basic_duty: %0d/%0d, required 25/230", duty_a, duty_b);
    end
  endtask

  task automatic test_hysteresis();
    repeat (NS) do_conv(5, 27, 1'b0);
    n_checks++;
    if (duty_a !== 8'd25) begin
      n_fail++;
      $display("FAIL hyst_hold: duty %0d, required 25", duty_a);
    end
    repeat (NS) do_conv(4, 29, 1'b0);
    n_checks++;
    if (duty_a !== 8'd29) begin
      n_fail++;
      $display("FAIL hyst_move: duty %0d, required 29", duty_a);
    end
  endtask

  task automatic test_invert();
    repeat (NS) do_conv(3, 200, 1'b0);
    n_checks++;
    if (duty_b !== 8'd55 || duty_a !== 8'd200) begin
      n_fail++;
      $display("FAIL invert_duty: %0d/%0d, required 200/55", duty_a, duty_b);
    end
  endtask

  task automatic test_timeout();
    do_conv(0, 0, 1'b0);
    repeat (NS) do_conv(5, 100, 1'b0);
    n_checks++;
    if (duty_a !== 8'd100) begin
      n_fail++;
      $display("FAIL timeout_window: duty %0d, required 100", duty_a);
    end
    clear_err();
  endtask

  task automatic test_coincide();
    do_conv(2, 60, 1'b0);
    do_conv(6, 60, 1'b0);
    do_conv(1, 60, 1'b0);
    do_conv(TIMEOUT - 1, 100, 1'b0);
    n_checks++;
    if (duty_a !== 8'd70 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL coincide: duty %0d err %b, required 70 err 0",
               duty_a, err_a);
    end
  endtask

  task automatic test_random();
    int base = 128;
    int r, d, v;
    for (int k = 0; k < 40; k++) begin
      if (m_n == 0) begin
        base += $urandom_range(0, 16) - 8;
        if (base < 0) base = 0;
        if (base > 250) base = 250;
      end
      v = base + $urandom_range(0, 5);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_conv(0, 0, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) clear_err();
      end else begin
        d = (r == 1) ? TIMEOUT - 1 : $urandom_range(1, TIMEOUT - 2);
        do_conv(d, v, 1'b0);
      end
    end
    if (m_err) clear_err();
  endtask

  task automatic test_disable();
    bit ok, seen;
    int held;
    held = m_duty_a;
    wait_start(ok);
    repeat (2) tick_c();
    en = 1'b0;
    model_disable();
    repeat (3) tick_c();
    conv_done = 1'b1;
    conv_data = 8'd77;
    tick_c();
    conv_done = 1'b0;
    n_checks++;
    if (dv_a !== 1'b0 || duty_a !== 8'(held)) begin
      n_fail++;
      $display("FAIL disable_drop: dv %b duty %0d, required dv 0 duty %0d",
               dv_a, duty_a, held);
    end
    seen = 0;
    repeat (40) begin
      tick_c();
      if (start_a || dv_a) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL disable_quiet: start/dv seen 1, required 0");
    end
    en = 1'b1;
    repeat (NS) do_conv(5, held, 1'b0);
  endtask

  task automatic test_async_reset();
    bit ok, wr;
    do_conv(0, 0, 1'b0);
    wait_start(ok);
    repeat (2) tick_c();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (start_a !== 0 || dv_a !== 0 || duty_a !== 0 || err_a !== 0 ||
        duty_b !== 0 || err_b !== 0) begin
      n_fail++;
      $display("FAIL async_reset: duty %0d/%0d err %b/%b, required all 0",
               duty_a, duty_b, err_a, err_b);
    end
    en = 1'b0;
    model_reset();
    repeat (2) tick_c();
    rst = 1'b0;
    conv_done = 1'b1;
    conv_data = 8'd250;
    tick_c();
    conv_done = 1'b0;
    en = 1'b1;
    repeat (2) tick_c();
    conv_done = 1'b1;
    tick_c();
    conv_done = 1'b0;
    n_checks++;
    if (dv_a !== 1'b0 || start_a !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_done: dv %b start %b, required 0 0",
               dv_a, start_a);
    end
    for (int i = 0; i < NS; i++) do_conv(5, 40 + 8 * i, 1'b0);
    model_sample(0, wr);
    m_sum = 0; m_n = 0;
    n_checks++;
    if (duty_a !== 8'd52 || duty_b !== 8'd203) begin
      n_fail++;
      $display("FAIL post_reset_window: %0d/%0d, required 52/203",
               duty_a, duty_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hysteresis();
    test_invert();
    test_timeout();
    test_coincide();
    test_random();
    test_disable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
